rs232rx: RTL and testbench

Asynchronous serial (8N1) receiver, the receive-side counterpart of the team's RS-232 transmitter. It synchronizes `serial_in`, finds the start bit, and samples eight data bits LSB-first at mid-bit. It checks the stop bit and hands each good byte to the core over a one-entry valid/ready buffer. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/rs232_pkg.sv | 29 ++
 rtl/rs232rx_sync2.sv | 25 ++
 rtl/rs232rx.sv | 208 ++++++++++++++++++++
 tb/tb_rs232rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: receiver FSM states, 8N1 frame constants,
// bit-period rounding and the 2-of-3 majority vote.
package rs232_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Clock cycles per bit, rounded to nearest; zero when the rate is unset.
   function automatic int bit_period(input int frequency, input int bps);
      if (bps == 0) begin
         return 0;
      end else begin
         return (frequency + bps / 2) / bps;
      end
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs232rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// a parameter so idle-high lines come out of reset inactive.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] ff_r;

   // Two-stage shift into the clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ff_r <= {2{RESET_VAL}};
      end else begin
         ff_r <= {ff_r[0], d};
      end
   end

   assign q = ff_r[1];

endmodule

// File: rtl/rs232rx.sv
// 8N1 serial receiver with one-entry valid/ready output buffer.
// Optional build macro RS232RX_MAJORITY_EN: 2-of-3 majority bit decisions.
module rs232rx
   import rs232_pkg::*;
#(
   parameter int frequency   = 0,
   parameter int bps         = 0,
   parameter int period      = bit_period(frequency, bps),
   parameter int TTYCLK_SIGN = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int TW = TTYCLK_SIGN + 1;
   localparam int CW = $clog2(DATA_BITS);
`ifdef RS232RX_MAJORITY_EN
   // One cycle later so the +1 neighbour is on rx when the timer expires.
   localparam int START_LOAD = period / 2 - 1;
`else
   localparam int START_LOAD = period / 2 - 2;
`endif
   localparam logic [TW-1:0] START_TICKS = TW'(START_LOAD);
   localparam logic [TW-1:0] BIT_TICKS   = TW'(period - 2);
   localparam logic [TW-1:0] ONE_TICK    = TW'(1);
   localparam logic [CW-1:0] LAST_COUNT  = CW'(DATA_BITS - 1);

   rx_state_t             state_r, state_next_s;
   logic                  rx_s;
   logic                  bit_s;
   logic                  expired_s;
   logic [TW-1:0]         timer_r;
   logic [CW-1:0]         count_r;
   logic [DATA_BITS-1:0]  shift_r;
   logic [7:0]            data_r;
   logic                  valid_r;
   logic                  framing_error_r;
   logic                  overrun_r;
   logic                  load_start_s;
   logic                  load_bit_s;
   logic                  load_count_s;
   logic                  shift_s;
   logic                  deliver_s;
   logic                  frame_err_s;

   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (serial_in),
      .q     (rx_s)
   );

`ifdef RS232RX_MAJORITY_EN
   logic rx_d1_r, rx_d2_r;

   // Keep the two previous rx samples for the majority vote.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_d1_r <= 1'b1;
         rx_d2_r <= 1'b1;
      end else begin
         rx_d1_r <= rx_s;
         rx_d2_r <= rx_d1_r;
      end
   end

   assign bit_s = maj3(rx_s, rx_d1_r, rx_d2_r);
`else
   assign bit_s = rx_s;
`endif

   assign expired_s = timer_r[TTYCLK_SIGN];

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (!rx_s) state_next_s = START; else state_next_s = IDLE;
         START:   if (expired_s) state_next_s = bit_s ? IDLE : DATA;
                  else state_next_s = START;
         DATA:    if (expired_s && (count_r == {CW{1'b0}})) state_next_s = STOP;
                  else state_next_s = DATA;
         STOP:    if (expired_s) state_next_s = bit_s ? IDLE : BREAK;
                  else state_next_s = STOP;
         BREAK:   if (rx_s) state_next_s = IDLE; else state_next_s = BREAK;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM control outputs.
   always_comb begin
      load_start_s = 1'b0;
      load_bit_s   = 1'b0;
      load_count_s = 1'b0;
      shift_s      = 1'b0;
      deliver_s    = 1'b0;
      frame_err_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rx_s) load_start_s = 1'b1; else load_start_s = 1'b0;
         end
         START: begin
            if (expired_s && !bit_s) begin
               load_bit_s   = 1'b1;
               load_count_s = 1'b1;
            end else begin
               load_bit_s   = 1'b0;
            end
         end
         DATA: begin
            if (expired_s) begin
               shift_s    = 1'b1;
               load_bit_s = 1'b1;
            end else begin
               shift_s    = 1'b0;
            end
         end
         STOP: begin
            if (expired_s) begin
               deliver_s   = bit_s;
               frame_err_s = ~bit_s;
            end else begin
               deliver_s   = 1'b0;
            end
         end
         default: begin
            deliver_s = 1'b0;
         end
      endcase
   end

   // Bit timer, bit counter and shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_r <= {TW{1'b0}};
         count_r <= {CW{1'b0}};
         shift_r <= {DATA_BITS{1'b0}};
      end else begin
         if (load_start_s) begin
            timer_r <= START_TICKS;
         end else if (load_bit_s) begin
            timer_r <= BIT_TICKS;
         end else if (!expired_s) begin
            timer_r <= timer_r - ONE_TICK;
         end else begin
            timer_r <= timer_r;
         end
         if (load_count_s) begin
            count_r <= LAST_COUNT;
         end else if (shift_s) begin
            count_r <= count_r - CW'(1);
         end else begin
            count_r <= count_r;
         end
         if (shift_s) begin
            shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
         end else begin
            shift_r <= shift_r;
         end
      end
   end

   // One-entry output buffer with overrun and framing-error pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_r          <= 8'h00;
         valid_r         <= 1'b0;
         framing_error_r <= 1'b0;
         overrun_r       <= 1'b0;
      end else begin
         framing_error_r <= frame_err_s;
         overrun_r       <= 1'b0;
         if (deliver_s) begin
            if (!valid_r || ready) begin
               data_r  <= shift_r;
               valid_r <= 1'b1;
            end else begin
               overrun_r <= 1'b1;
            end
         end else if (valid_r && ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   assign data          = data_r;
   assign valid         = valid_r;
   assign framing_error = framing_error_r;
   assign overrun       = overrun_r;

endmodule

// File: tb/tb_rs232rx.sv
// Directed bench for rs232rx at 1600 Hz / 100 bps (16 cycles per bit):
// a table of clean frames plus hand-written glitch, break, overrun and reset cases.
module tb_rs232rx;

`ifdef RS232RX_MAJORITY_EN
   localparam int LAT = 156;
   localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
   localparam int LAT = 155;
   localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       serial_in;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       framing_error;
   logic       overrun;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rise_cnt = 0, rise_cyc = 0, valid_hi = 0, fe_cnt = 0, fe_cyc = 0;
   int ov_cnt = 0, ov_cyc = 0;
   logic [7:0] rise_data = 8'h00;
   logic valid_q = 1'b0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs[6];

   rs232rx #(.frequency(1600), .bps(100)) dut (
      .clock         (clock),
      .reset         (reset),
      .serial_in     (serial_in),
      .data          (data),
      .valid         (valid),
      .ready         (ready),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (valid && !valid_q) begin
         rise_cnt  <= rise_cnt + 1;
         rise_cyc  <= cyc;
         rise_data <= data;
      end
      if (valid) valid_hi <= valid_hi + 1;
      if (framing_error) begin
         fe_cnt <= fe_cnt + 1;
         fe_cyc <= cyc;
      end
      if (overrun) begin
         ov_cnt <= ov_cnt + 1;
         ov_cyc <= cyc;
      end
      valid_q <= valid;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one frame from a negedge; gbit/goff invert one cycle of a data bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit,
                             input int goff, input int cut);
      logic [9:0] bits;
      int n;
      bits = {stop, b, 1'b0};
      n = 0;
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 16; j++) begin
            if (n < cut) begin
               serial_in = (i == gbit + 1 && j == goff) ? ~bits[i] : bits[i];
               @(negedge clock);
               n++;
            end
         end
      end
   endtask

   initial begin
      int r0, h0, f0, o0, s1;
      vecs[0] = '{8'h55, 8'h55};
      vecs[1] = '{8'hA3, 8'hA3};
      vecs[2] = '{8'h00, 8'h00};
      vecs[3] = '{8'hFF, 8'hFF};
      vecs[4] = '{8'h80, 8'h80};
      vecs[5] = '{8'h01, 8'h01};

      reset = 1'b1;
      serial_in = 1'b1;
      ready = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_fe", framing_error, 0);
      check("rst_ov", overrun, 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      for (int k = 0; k < 6; k++) begin
         r0 = rise_cnt;
         h0 = valid_hi;
         send_frame(vecs[k].tx, 1'b1, 99, 0, 160);
         check("tbl_rises", rise_cnt - r0, 1);
         check("tbl_latency", rise_cyc - start_cyc, LAT);
         check("tbl_data", rise_data, vecs[k].exp_data);
         check("tbl_valid_width", valid_hi - h0, 1);
         check("tbl_valid_end", valid, 0);
      end

      r0 = rise_cnt;
      f0 = fe_cnt;
      serial_in = 1'b0;
      repeat (4) @(negedge clock);
      serial_in = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_rises", rise_cnt - r0, 0);
      check("glitch_fe", fe_cnt - f0, 0);

      r0 = rise_cnt;
      f0 = fe_cnt;
      send_frame(8'h00, 1'b0, 99, 0, 160);
      repeat (320) @(negedge clock);
      check("break_fe", fe_cnt - f0, 1);
      check("break_fe_latency", fe_cyc - start_cyc, LAT);
      check("break_rises", rise_cnt - r0, 0);
      serial_in = 1'b1;
      repeat (32) @(negedge clock);
      send_frame(8'hA3, 1'b1, 99, 0, 160);
      check("after_break_data", rise_data, 8'hA3);
      check("after_break_rises", rise_cnt - r0, 1);
      check("after_break_fe", fe_cnt - f0, 1);

      ready = 1'b0;
      r0 = rise_cnt;
      o0 = ov_cnt;
      send_frame(8'h12, 1'b1, 99, 0, 160);
      send_frame(8'h34, 1'b1, 99, 0, 160);
      s1 = start_cyc;
      check("ovr_count", ov_cnt - o0, 1);
      check("ovr_latency", ov_cyc - s1, LAT);
      check("ovr_valid", valid, 1);
      check("ovr_data", data, 8'h12);
      check("ovr_rises", rise_cnt - r0, 1);
      ready = 1'b1;
      @(negedge clock);
      ready = 1'b0;
      @(negedge clock);
      check("drain_valid", valid, 0);
      check("drain_data_hold", data, 8'h12);

      ready = 1'b1;
      send_frame(8'hFF, 1'b1, 99, 0, 88);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_valid", valid, 0);
      check("midrst_data", data, 0);
      check("midrst_fe", framing_error, 0);
      check("midrst_ov", overrun, 0);
      reset = 1'b0;
      serial_in = 1'b1;
      repeat (160) @(negedge clock);
      r0 = rise_cnt;
      send_frame(8'h3C, 1'b1, 99, 0, 160);
      check("postrst_data", rise_data, 8'h3C);
      check("postrst_rises", rise_cnt - r0, 1);

      r0 = rise_cnt;
      send_frame(8'h00, 1'b1, 3, 8, 160);
      check("spike_data", rise_data, GLITCH_EXP);
      check("spike_latency", rise_cyc - start_cyc, LAT);
      check("spike_rises", rise_cnt - r0, 1);

      repeat (4) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
